// File: rtl/race_pkg.sv
// Shared colours, lane FSM states and default track geometry for the race scene renderer.
// Pure declarations; no clocked logic, no latency, no flow control.
package race_pkg;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_TRACK = 3'b111;
  localparam logic [2:0] COL_BG    = 3'b010;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam int DEF_N_LANES     = 3;
  localparam int DEF_TRACK_X0    = 197;
  localparam int DEF_LANE_W      = 82;
  localparam int DEF_CAR_W       = 80;
  localparam int DEF_CAR_H       = 121;
  localparam int DEF_CAR_Y       = 357;
  localparam int DEF_BAR_W       = 30;
  localparam int DEF_BAR_H       = 64;
  localparam int DEF_SLIDE_STEP  = 4;
  localparam int DEF_SCROLL_STEP = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SLIDE_L = 2'd1,
    SLIDE_R = 2'd2
  } lane_state_t;

  // The sprite ROMs store colour as {r,g,b}; the display wants {b,g,r}.
  function automatic logic [2:0] rom_pix(input logic [2:0] d);
    return {d[0], d[1], d[2]};
  endfunction

endpackage

// File: rtl/lane_fsm.sv
// Lane-change FSM and car x position; updates only on frame_tick, requests ignored while sliding.
// Latency: state/car_x change on the edge where tick is high; no backpressure (level inputs).
module lane_fsm
  import race_pkg::*;
#(
  parameter int N_LANES    = DEF_N_LANES,
  parameter int TRACK_X0   = DEF_TRACK_X0,
  parameter int LANE_W     = DEF_LANE_W,
  parameter int SLIDE_STEP = DEF_SLIDE_STEP
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tick,
  input  logic                       left,
  input  logic                       right,
  output logic [$clog2(N_LANES)-1:0] lane,
  output logic [9:0]                 car_x,
  output logic                       busy
);

  localparam int LW = $clog2(N_LANES);
  localparam logic [LW-1:0] CENTER   = LW'(N_LANES / 2);
  localparam logic [LW-1:0] MAX_LANE = LW'(N_LANES - 1);
  localparam logic [9:0]    STEP     = 10'(SLIDE_STEP);

  function automatic logic [9:0] lane_pos(input logic [LW-1:0] l);
    return 10'(TRACK_X0 + int'(l) * LANE_W);
  endfunction

  lane_state_t   state_q, state_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [9:0]    car_x_q, car_x_d;
  logic [9:0]    target;

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    car_x_d = car_x_q;
    // lane_q already holds the destination once a slide has started
    target  = lane_pos(lane_q);
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (left && !right && lane_q != '0) begin
            lane_d  = lane_q - LW'(1);
            state_d = SLIDE_L;
          end else if (right && !left && lane_q != MAX_LANE) begin
            lane_d  = lane_q + LW'(1);
            state_d = SLIDE_R;
          end
        end
        SLIDE_L: begin
          if (car_x_q - target <= STEP) begin
            car_x_d = target;
            state_d = IDLE;
          end else begin
            car_x_d = car_x_q - STEP;
          end
        end
        SLIDE_R: begin
          if (target - car_x_q <= STEP) begin
            car_x_d = target;
            state_d = IDLE;
          end else begin
            car_x_d = car_x_q + STEP;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      lane_q  <= CENTER;
      car_x_q <= lane_pos(CENTER);
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      car_x_q <= car_x_d;
    end
  end

  assign lane  = lane_q;
  assign car_x = car_x_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: rtl/race_scene_renderer.sv
// Renders track, boundary bars and car sprite for a VGA raster; drives sprite ROM addresses.
// Latency: pix_out is 2 cycles behind hcount/vcount; no backpressure, one pixel per clock.
module race_scene_renderer
  import race_pkg::*;
#(
  parameter int N_LANES     = DEF_N_LANES,
  parameter int TRACK_X0    = DEF_TRACK_X0,
  parameter int LANE_W      = DEF_LANE_W,
  parameter int CAR_W       = DEF_CAR_W,
  parameter int CAR_H       = DEF_CAR_H,
  parameter int CAR_Y       = DEF_CAR_Y,
  parameter int BAR_W       = DEF_BAR_W,
  parameter int BAR_H       = DEF_BAR_H,
  parameter int SLIDE_STEP  = DEF_SLIDE_STEP,
  parameter int SCROLL_STEP = DEF_SCROLL_STEP
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       left,
  input  logic                       right,
  input  logic                       scroll_en,
  input  logic [9:0]                 hcount,
  input  logic [9:0]                 vcount,
  output logic [13:0]                car_addr,
  input  logic [2:0]                 car_data,
  output logic [13:0]                bar_l_addr,
  output logic [13:0]                bar_r_addr,
  input  logic [2:0]                 bar_l_data,
  input  logic [2:0]                 bar_r_data,
  output logic [2:0]                 pix_out,
  output logic [$clog2(N_LANES)-1:0] lane,
  output logic                       busy
);

  localparam logic [10:0] TRK_L  = 11'(TRACK_X0);
  localparam logic [10:0] TRK_R  = 11'(TRACK_X0 + N_LANES * LANE_W);
  localparam logic [10:0] LBAR_L = 11'(TRACK_X0 - BAR_W);
  localparam logic [10:0] RBAR_R = 11'(TRACK_X0 + N_LANES * LANE_W + BAR_W);
  localparam logic [10:0] CAR_T  = 11'(CAR_Y);
  localparam logic [10:0] CAR_B  = 11'(CAR_Y + CAR_H);

  logic [9:0]  vcount_q, vcount_d;
  logic        frame_tick;
  logic [9:0]  scroll_off_q, scroll_off_d;
  logic [9:0]  car_x;

  logic        act_q, act_d;
  logic        car_q, car_d;
  logic        trk_q, trk_d;
  logic        lbar_q, lbar_d;
  logic        rbar_q, rbar_d;
  logic [13:0] car_addr_q, car_addr_d;
  logic [13:0] bar_l_addr_q, bar_l_addr_d;
  logic [13:0] bar_r_addr_q, bar_r_addr_d;
  logic [2:0]  pix_q, pix_d;

  logic [10:0] h11, v11, car_l, car_r, bar_row, scroll_sum;
  logic [2:0]  car_px;

  lane_fsm #(
    .N_LANES    (N_LANES),
    .TRACK_X0   (TRACK_X0),
    .LANE_W     (LANE_W),
    .SLIDE_STEP (SLIDE_STEP)
  ) u_lane (
    .clk   (clk),
    .reset (reset),
    .tick  (frame_tick),
    .left  (left),
    .right (right),
    .lane  (lane),
    .car_x (car_x),
    .busy  (busy)
  );

  // One tick per frame, on the first line of vertical blanking.
  assign frame_tick = (vcount == 10'(V_ACTIVE)) && (vcount_q != 10'(V_ACTIVE));

  always_comb begin
    vcount_d     = vcount;
    scroll_off_d = scroll_off_q;
    scroll_sum   = 11'(scroll_off_q) + 11'(SCROLL_STEP);
    if (frame_tick && scroll_en) begin
      scroll_off_d = (scroll_sum >= 11'(BAR_H)) ? 10'(scroll_sum - 11'(BAR_H))
                                                : 10'(scroll_sum);
    end
  end

  // Stage 1: region decode and ROM addresses, all derived from the raster position.
  always_comb begin
    h11     = {1'b0, hcount};
    v11     = {1'b0, vcount};
    car_l   = {1'b0, car_x};
    car_r   = car_l + 11'(CAR_W);
    bar_row = (v11 + 11'(scroll_off_q)) % 11'(BAR_H);

    act_d  = (h11 < 11'(H_ACTIVE)) && (v11 < 11'(V_ACTIVE));
    car_d  = (h11 >= car_l) && (h11 < car_r) && (v11 >= CAR_T) && (v11 < CAR_B);
    trk_d  = (h11 >= TRK_L) && (h11 < TRK_R);
    lbar_d = (h11 >= LBAR_L) && (h11 < TRK_L);
    rbar_d = (h11 >= TRK_R) && (h11 < RBAR_R);

    car_addr_d   = '0;
    bar_l_addr_d = '0;
    bar_r_addr_d = '0;
    if (car_d) begin
      car_addr_d = 14'(v11 - CAR_T) * 14'(CAR_W) + 14'(h11 - car_l);
    end
    if (lbar_d) begin
      bar_l_addr_d = 14'(bar_row) * 14'(BAR_W) + 14'(h11 - LBAR_L);
    end
    if (rbar_d) begin
      bar_r_addr_d = 14'(bar_row) * 14'(BAR_W) + 14'(h11 - TRK_R);
    end
  end

  // Stage 2: layer priority; a black car pixel lets the layer beneath show through.
  always_comb begin
    car_px = rom_pix(car_data);
    pix_d  = COL_BG;
    if (!act_q) begin
      pix_d = COL_BLACK;
    end else if (car_q && car_px != COL_BLACK) begin
      pix_d = car_px;
    end else if (trk_q) begin
      pix_d = COL_TRACK;
    end else if (lbar_q) begin
      pix_d = rom_pix(bar_l_data);
    end else if (rbar_q) begin
      pix_d = rom_pix(bar_r_data);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vcount_q     <= '0;
      scroll_off_q <= '0;
      act_q        <= 1'b0;
      car_q        <= 1'b0;
      trk_q        <= 1'b0;
      lbar_q       <= 1'b0;
      rbar_q       <= 1'b0;
      car_addr_q   <= '0;
      bar_l_addr_q <= '0;
      bar_r_addr_q <= '0;
      pix_q        <= COL_BLACK;
    end else begin
      vcount_q     <= vcount_d;
      scroll_off_q <= scroll_off_d;
      act_q        <= act_d;
      car_q        <= car_d;
      trk_q        <= trk_d;
      lbar_q       <= lbar_d;
      rbar_q       <= rbar_d;
      car_addr_q   <= car_addr_d;
      bar_l_addr_q <= bar_l_addr_d;
      bar_r_addr_q <= bar_r_addr_d;
      pix_q        <= pix_d;
    end
  end

  assign car_addr   = car_addr_q;
  assign bar_l_addr = bar_l_addr_q;
  assign bar_r_addr = bar_r_addr_q;
  assign pix_out    = pix_q;

endmodule

// File: tb/tb_race_scene_renderer.sv
// Directed bench for race_scene_renderer: pixel expectations queued at drive time, popped at output.
module tb_race_scene_renderer;

  logic        clk = 1'b0;
  logic        reset;
  logic        left, right, scroll_en;
  logic [9:0]  hcount, vcount;
  logic [13:0] car_addr, bar_l_addr, bar_r_addr;
  logic [2:0]  car_data, bar_l_data, bar_r_data;
  logic [2:0]  pix_out;
  logic [1:0]  lane;
  logic        busy;

  logic [2:0]  car_rom, bl_rom, br_rom;
  logic [2:0]  exp_q[$];
  int          n_pass = 0;
  int          n_fail = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  assign car_data   = car_rom;
  assign bar_l_data = bl_rom;
  assign bar_r_data = br_rom;

  race_scene_renderer dut (
    .clk        (clk),
    .reset      (reset),
    .left       (left),
    .right      (right),
    .scroll_en  (scroll_en),
    .hcount     (hcount),
    .vcount     (vcount),
    .car_addr   (car_addr),
    .car_data   (car_data),
    .bar_l_addr (bar_l_addr),
    .bar_r_addr (bar_r_addr),
    .bar_l_data (bar_l_data),
    .bar_r_data (bar_r_data),
    .pix_out    (pix_out),
    .lane       (lane),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one raster position, queue its expected colour, compare when it emerges.
  task automatic pix(input string tag, input int h, input int v, input logic [2:0] exp);
    logic [2:0] e;
    @(negedge clk);
    hcount = 10'(h);
    vcount = 10'(v);
    exp_q.push_back(exp);
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 32'(0), 32'(1));
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(pix_out), 32'(e));
    end
  endtask

  // Present a position and step one edge so the stage-1 addresses are visible.
  task automatic at(input int h, input int v);
    @(negedge clk);
    hcount = 10'(h);
    vcount = 10'(v);
    @(negedge clk);
  endtask

  task automatic frame(input logic l, input logic r);
    @(negedge clk);
    left   = l;
    right  = r;
    vcount = 10'd480;
    @(negedge clk);
    vcount = 10'd0;
    left   = 1'b0;
    right  = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; left = 1'b0; right = 1'b0; scroll_en = 1'b0;
    hcount = '0; vcount = '0;
    car_rom = 3'b000; bl_rom = 3'b011; br_rom = 3'b100;
    repeat (3) @(negedge clk);
    chk("rst_lane", 32'(lane), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_pix", 32'(pix_out), 32'(0));
    chk("rst_car_addr", 32'(car_addr), 32'(0));
    chk("rst_bar_l_addr", 32'(bar_l_addr), 32'(0));
    chk("rst_bar_r_addr", 32'(bar_r_addr), 32'(0));
    chk("rst_car_x", 32'(dut.u_lane.car_x_q), 32'(279));
    chk("rst_scroll", 32'(dut.scroll_off_q), 32'(0));
    reset = 1'b1;

    pix("track_300_400", 300, 400, 3'b111);
    pix("bg_100_10", 100, 10, 3'b010);
    pix("blank_650_10", 650, 10, 3'b000);
    pix("blank_10_480", 10, 480, 3'b000);
    pix("track_442", 442, 0, 3'b111);
    pix("lbar_196", 196, 100, 3'b110);
    pix("rbar_450", 450, 0, 3'b001);
    pix("bg_473", 473, 0, 3'b010);
    pix("bg_166", 166, 0, 3'b010);

    pix("car_transp", 279, 357, 3'b111);
    car_rom = 3'b001;
    pix("car_001", 279, 357, 3'b100);
    car_rom = 3'b110;
    pix("car_corner", 358, 477, 3'b011);
    at(358, 477);
    chk("car_addr_corner", 32'(car_addr), 32'(9679));
    at(359, 477);
    chk("car_addr_outside", 32'(car_addr), 32'(0));
    car_rom = 3'b000;

    at(170, 5);
    chk("bar_l_addr_s0", 32'(bar_l_addr), 32'(153));
    at(450, 0);
    chk("bar_r_addr_s0", 32'(bar_r_addr), 32'(7));
    chk("bar_l_addr_off", 32'(bar_l_addr), 32'(0));

    frame(1'b1, 1'b1);
    chk("both_lane", 32'(lane), 32'(1));
    chk("both_busy", 32'(busy), 32'(0));
    chk("both_x", 32'(dut.u_lane.car_x_q), 32'(279));

    for (int f = 1; f <= 30; f++) begin
      frame(1'b1, 1'b0);
      chk($sformatf("left_x_f%0d", f), 32'(dut.u_lane.car_x_q),
          (f == 1) ? 32'(279) : (f <= 21) ? 32'(279 - 4 * (f - 1)) : 32'(197));
      chk($sformatf("left_busy_f%0d", f), 32'(busy), (f <= 21) ? 32'(1) : 32'(0));
    end
    chk("left_lane_end", 32'(lane), 32'(0));

    for (int f = 1; f <= 22; f++) begin
      frame(1'b0, 1'b1);
      chk($sformatf("right_x_f%0d", f), 32'(dut.u_lane.car_x_q),
          (f == 22) ? 32'(279) : 32'(197 + 4 * (f - 1)));
      chk($sformatf("right_lane_f%0d", f), 32'(lane), 32'(1));
    end
    chk("right_busy_end", 32'(busy), 32'(0));
    frame(1'b0, 1'b0);
    chk("right_idle_x", 32'(dut.u_lane.car_x_q), 32'(279));

    scroll_en = 1'b1;
    for (int f = 0; f < 33; f++) frame(1'b0, 1'b0);
    scroll_en = 1'b0;
    chk("scroll_33", 32'(dut.scroll_off_q), 32'(2));
    frame(1'b0, 1'b0);
    chk("scroll_hold", 32'(dut.scroll_off_q), 32'(2));
    at(170, 0);
    chk("bar_l_addr_s2", 32'(bar_l_addr), 32'(63));
    pix("lbar_scrolled", 170, 0, 3'b110);

    frame(1'b0, 1'b1);
    chk("slider_lane", 32'(lane), 32'(2));
    for (int f = 2; f <= 5; f++) frame(1'b0, 1'b0);
    chk("slider_x_f5", 32'(dut.u_lane.car_x_q), 32'(295));
    chk("slider_busy", 32'(busy), 32'(1));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_x", 32'(dut.u_lane.car_x_q), 32'(279));
    chk("abort_lane", 32'(lane), 32'(1));
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_scroll", 32'(dut.scroll_off_q), 32'(0));
    chk("abort_pix", 32'(pix_out), 32'(0));
    reset = 1'b1;
    pix("post_abort_bg", 100, 10, 3'b010);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
